// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared opcodes, FSM state type and the radix-4 Booth digit
// select used by seq_alu when FAST_MUL_EN is defined.
package seq_alu_pkg;

  localparam int unsigned OPW = 5;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPW-1:0] OP_SHRA = 5'b01000;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPW-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

  // Booth digit in {-2..+2} from multiplier bits {b[2i+1], b[2i], b[2i-1]}.
  function automatic logic signed [2:0] booth4_digit(input logic [2:0] trip);
    logic signed [2:0] d;
    case (trip)
      3'b001, 3'b010: d = 3'sd1;
      3'b011:         d = 3'sd2;
      3'b100:         d = -3'sd2;
      3'b101, 3'b110: d = -3'sd1;
      default:        d = 3'sd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/result bus between the control unit (master) and the
// sequential ALU (slave).
//   start, opcode, a_in, b_in              : master -> slave
//   busy, done, result_lo, result_hi,
//   div_by_zero, invalid_op                : slave -> master
interface seq_alu_if
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [OPW-1:0]   opcode;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;
  logic             invalid_op;

  modport master (
    output start, opcode, a_in, b_in,
    input  busy, done, result_lo, result_hi, div_by_zero, invalid_op
  );

  modport slave (
    input  start, opcode, a_in, b_in,
    output busy, done, result_lo, result_hi, div_by_zero, invalid_op
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: signed division by restoring iteration on magnitudes.
//   go          : load operands (one cycle); iterations start next cycle
//   dividend,
//   divisor     : sampled only when go is high
//   ready_c     : high in the cycle whose closing edge retires the last step
//   quot_c,
//   rem_c       : sign-corrected quotient / remainder of the held magnitudes
//   div_by_zero : registered flag for the most recent go
// A zero divisor skips iteration and holds quotient=all ones, remainder=dividend.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready_c,
  output logic [WIDTH-1:0] quot_c,
  output logic [WIDTH-1:0] rem_c,
  output logic             div_by_zero
);
  localparam int unsigned CNTW = $clog2(WIDTH);

  logic             run_q, run_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh;

  // |MIN| wraps to MIN, which is still the right unsigned magnitude.
  assign a_mag  = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign rem_sh = {rem_q, quot_q[WIDTH-1]};

  assign ready_c     = run_q && (cnt_q == CNTW'(WIDTH - 1));
  assign quot_c      = negq_q ? -quot_q : quot_q;
  assign rem_c       = negr_q ? -rem_q  : rem_q;
  assign div_by_zero = dbz_q;

  // Load / one restoring step per cycle.
  always_comb begin
    run_d  = run_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    negq_d = negq_q;
    negr_d = negr_q;
    dbz_d  = dbz_q;
    if (go) begin
      cnt_d  = '0;
      dvs_d  = b_mag;
      negr_d = dividend[WIDTH-1];
      if (divisor == '0) begin
        run_d  = 1'b0;
        dbz_d  = 1'b1;
        quot_d = '1;
        rem_d  = a_mag;
        negq_d = 1'b0;
      end else begin
        run_d  = 1'b1;
        dbz_d  = 1'b0;
        quot_d = a_mag;
        rem_d  = '0;
        negq_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      end
    end else if (run_q) begin
      if (rem_sh >= {1'b0, dvs_q}) begin
        rem_d  = WIDTH'(rem_sh - {1'b0, dvs_q});
        quot_d = {quot_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d  = rem_sh[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNTW'(1);
      if (ready_c) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      dbz_q  <= dbz_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with registered HI:LO result and start/busy/done.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : seq_alu_if.slave (start/opcode/a_in/b_in in;
//                busy/done/result_lo/result_hi/div_by_zero/invalid_op out)
// Single-cycle ops finish in one cycle; MUL is an inline Booth multiplier,
// DIV is delegated to seq_divider and finished in the FIX state.
// Define FAST_MUL_EN for radix-4 Booth (WIDTH/2 steps instead of WIDTH).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     reset,
  seq_alu_if.slave bus
);
  localparam int unsigned W2   = 2 * WIDTH;
  localparam int unsigned CNTW = $clog2(WIDTH);
`ifdef FAST_MUL_EN
  localparam int unsigned MUL_STEPS = WIDTH / 2;
  localparam int unsigned MSH       = 2;
`else
  localparam int unsigned MUL_STEPS = WIDTH;
  localparam int unsigned MSH       = 1;
`endif

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             dbz_q, dbz_d;
  logic             inv_q, inv_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic             prev_q, prev_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic             div_go;
  logic             div_ready;
  logic             div_dbz;
  logic [WIDTH-1:0] div_quot, div_rem;

  logic [WIDTH-1:0] alu_lo;
  logic             alu_carry;
  logic             alu_valid;
  logic [SHW-1:0]   sh_amt, rot_amt;
  logic [WIDTH:0]   add_w, sub_w;
  logic [W2-1:0]    acc_step;

  assign sh_amt  = bus.b_in[SHW-1:0];
  assign rot_amt = SHW'(32'(sh_amt) % WIDTH);
  assign add_w   = {1'b0, bus.a_in} + {1'b0, bus.b_in};
  assign sub_w   = {1'b0, bus.a_in} - {1'b0, bus.b_in};

  // Single-cycle result; hi[0] carries carry-out (ADD) or no-borrow (SUB).
  always_comb begin
    alu_lo    = '0;
    alu_carry = 1'b0;
    alu_valid = 1'b1;
    case (bus.opcode)
      OP_ADD:  begin alu_lo = add_w[WIDTH-1:0]; alu_carry = add_w[WIDTH]; end
      OP_SUB:  begin alu_lo = sub_w[WIDTH-1:0]; alu_carry = ~sub_w[WIDTH]; end
      OP_AND:  alu_lo = bus.a_in & bus.b_in;
      OP_OR:   alu_lo = bus.a_in | bus.b_in;
      OP_SHR:  alu_lo = bus.a_in >> sh_amt;
      OP_SHRA: alu_lo = $signed(bus.a_in) >>> sh_amt;
      OP_SHL:  alu_lo = bus.a_in << sh_amt;
      // A shift by WIDTH yields zero, so amount 0 passes a_in through.
      OP_ROR:  alu_lo = (bus.a_in >> rot_amt) | (bus.a_in << (WIDTH - 32'(rot_amt)));
      OP_ROL:  alu_lo = (bus.a_in << rot_amt) | (bus.a_in >> (WIDTH - 32'(rot_amt)));
      OP_NEG:  alu_lo = '0 - bus.b_in;
      OP_NOT:  alu_lo = ~bus.b_in;
      default: alu_valid = 1'b0;
    endcase
  end

  // One Booth step: the accumulator wraps mod 2^W2, which is exact for a
  // signed WIDTH x WIDTH product.
`ifdef FAST_MUL_EN
  logic signed [2:0] digit;
  always_comb begin
    digit = booth4_digit({mq_q[1:0], prev_q});
    case (digit)
      3'sd1:   acc_step = acc_q + mcand_q;
      3'sd2:   acc_step = acc_q + (mcand_q << 1);
      -3'sd1:  acc_step = acc_q - mcand_q;
      -3'sd2:  acc_step = acc_q - (mcand_q << 1);
      default: acc_step = acc_q;
    endcase
  end
`else
  always_comb begin
    case ({mq_q[0], prev_q})
      2'b01:   acc_step = acc_q + mcand_q;
      2'b10:   acc_step = acc_q - mcand_q;
      default: acc_step = acc_q;
    endcase
  end
`endif

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .reset      (reset),
    .go         (div_go),
    .dividend   (bus.a_in),
    .divisor    (bus.b_in),
    .ready_c    (div_ready),
    .quot_c     (div_quot),
    .rem_c      (div_rem),
    .div_by_zero(div_dbz)
  );

  // Next-state, result capture and multiplier sequencing.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dbz_d   = dbz_q;
    inv_d   = inv_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mq_d    = mq_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    div_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.opcode)
            OP_MUL: begin
              state_d = MUL;
              busy_d  = 1'b1;
              acc_d   = '0;
              mcand_d = {{WIDTH{bus.a_in[WIDTH-1]}}, bus.a_in};
              mq_d    = bus.b_in;
              prev_d  = 1'b0;
              cnt_d   = '0;
            end
            OP_DIV: begin
              div_go  = 1'b1;
              busy_d  = 1'b1;
              state_d = (bus.b_in == '0) ? FIX : DIV;
            end
            default: begin
              done_d = 1'b1;
              lo_d   = alu_lo;
              hi_d   = {{(WIDTH-1){1'b0}}, alu_carry};
              dbz_d  = 1'b0;
              inv_d  = ~alu_valid;
            end
          endcase
        end
      end
      MUL: begin
        acc_d   = acc_step;
        mcand_d = mcand_q << MSH;
        mq_d    = mq_q >> MSH;
        prev_d  = mq_q[MSH-1];
        cnt_d   = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(MUL_STEPS - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          lo_d    = acc_step[WIDTH-1:0];
          hi_d    = acc_step[W2-1:WIDTH];
          dbz_d   = 1'b0;
          inv_d   = 1'b0;
        end
      end
      DIV: begin
        if (div_ready) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        lo_d    = div_quot;
        hi_d    = div_rem;
        dbz_d   = div_dbz;
        inv_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      dbz_q   <= 1'b0;
      inv_q   <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      mq_q    <= '0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dbz_q   <= dbz_d;
      inv_q   <= inv_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mq_q    <= mq_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result_lo   = lo_q;
  assign bus.result_hi   = hi_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.invalid_op  = inv_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu (WIDTH=32). Stimulus pushes the
// expected result and done cycle; a negedge monitor pops on every done.
module tb_seq_alu;
  import seq_alu_pkg::*;

`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 33;
`endif

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    logic        inv;
    int          cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  seq_alu_if #(.WIDTH(32)) bus ();

  seq_alu #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: plain arithmetic on the operation's definition.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] s;
    logic [63:0] p;
    longint      sa, sb_v, q, r;
    int          sh;
    e.lo = '0; e.hi = '0; e.dbz = 1'b0; e.inv = 1'b0; e.cyc = 1; e.name = "";
    sh = int'(b[4:0]);
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; e.lo = s[31:0]; e.hi = {31'b0, s[32]}; end
      OP_SUB: begin e.lo = a - b; e.hi = (a >= b) ? 32'd1 : 32'd0; end
      OP_AND: e.lo = a & b;
      OP_OR:  e.lo = a | b;
      OP_SHR: e.lo = a >> sh;
      OP_SHL: e.lo = a << sh;
      OP_SHRA: begin e.lo = a; for (int i = 0; i < sh; i++) e.lo = {e.lo[31], e.lo[31:1]}; end
      OP_ROR:  begin e.lo = a; for (int i = 0; i < sh; i++) e.lo = {e.lo[0], e.lo[31:1]}; end
      OP_ROL:  begin e.lo = a; for (int i = 0; i < sh; i++) e.lo = {e.lo[30:0], e.lo[31]}; end
      OP_NEG: e.lo = 32'd0 - b;
      OP_NOT: e.lo = ~b;
      OP_MUL: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        e.lo = p[31:0]; e.hi = p[63:32]; e.cyc = MUL_LAT;
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a; e.dbz = 1'b1; e.cyc = 2;
        end else begin
          sa = longint'($signed(a)); sb_v = longint'($signed(b));
          q = sa / sb_v; r = sa % sb_v;
          e.lo = q[31:0]; e.hi = r[31:0]; e.cyc = 34;
        end
      end
      default: e.inv = 1'b1;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    exp_t e;
    e = model(op, a, b);
    e.cyc = cyc + e.cyc;
    e.name = name;
    bus.start = 1'b1; bus.opcode = op; bus.a_in = a; bus.b_in = b;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.opcode = 5'($urandom);
    bus.a_in = $urandom;
    bus.b_in = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_busy", 64'(bus.busy), 64'd0);
  endtask

  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    wait_idle();
    issue(op, a, b, name);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pending op", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_lo"},  64'(bus.result_lo),   64'(mon_e.lo));
        chk({mon_e.name, "_hi"},  64'(bus.result_hi),   64'(mon_e.hi));
        chk({mon_e.name, "_dbz"}, 64'(bus.div_by_zero), 64'(mon_e.dbz));
        chk({mon_e.name, "_inv"}, 64'(bus.invalid_op),  64'(mon_e.inv));
        chk({mon_e.name, "_cyc"}, 64'(cyc),             64'(mon_e.cyc));
      end
    end
  end

  logic [4:0] op_tab [15] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
                              OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT, 5'h00, 5'h1F};

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    bus.start = 1'b0; bus.opcode = '0; bus.a_in = '0; bus.b_in = '0;
    reset = 1'b1;
    bus.start = 1'b1;  // reset must win over start
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_lo",   64'(bus.result_lo), 64'd0);
    chk("rst_hi",   64'(bus.result_hi), 64'd0);
    chk("rst_flags", 64'({bus.div_by_zero, bus.invalid_op}), 64'd0);
    bus.start = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    do_op(OP_MUL, 32'hFFFF_FFFD, 32'd7, "mul_m3x7");
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7d2");
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    do_op(OP_DIV, 32'd5, 32'd0, "div_by0");
    do_op(OP_ROR, 32'h8000_0001, 32'd1, "ror1");
    do_op(OP_SHRA, 32'h8000_0000, 32'd36, "shra36");
    do_op(OP_ADD, 32'hFFFF_FFFF, 32'd1, "add_carry");
    do_op(OP_SUB, 32'd5, 32'd7, "sub_borrow");
    do_op(OP_ROL, 32'h1234_5678, 32'd0, "rol0");
    do_op(5'b11111, 32'd1, 32'd2, "bad_op");
    do_op(OP_MUL, 32'h8000_0000, 32'h8000_0000, "mul_min_min");

    // start while busy must be ignored
    do_op(OP_MUL, 32'h0001_2345, 32'hFFFF_FF00, "mul_busy");
    repeat (3) @(negedge clk);
    chk("busy_mid_mul", 64'(bus.busy), 64'd1);
    bus.start = 1'b1; bus.opcode = OP_ADD;
    @(negedge clk);
    bus.start = 1'b0;

    // reset during a multiply aborts it
    do_op(OP_ADD, 32'h1234_5678, 32'd1, "add_pre_rst");
    do_op(OP_MUL, 32'h0000_0123, 32'h0000_0456, "mul_aborted");
    repeat (9) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_lo",   64'(bus.result_lo), 64'd0);
    chk("abort_hi",   64'(bus.result_hi), 64'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_pending", 64'(sb.size()), 64'd0);

    for (int i = 0; i < 60; i++) begin
      op = op_tab[$urandom_range(0, 14)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      if (op == OP_DIV && $urandom_range(0, 4) == 0) b = 32'd0;
      if (op == OP_DIV && $urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      do_op(op, a, b, $sformatf("rnd%0d_op%0h", i, op));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
